// File: rtl/syncfifo_buf.sv
// ---------------------------------------------------------------------------
// syncfifo_buf
//
// Single-clock FIFO on an inferred simple-dual-port RAM. It has full, empty
// and programmable almost-full/almost-empty flags, a fill count, sticky
// overflow/underflow error flags and a synchronous flush. It supports either
// a standard read mode or a first-word-fall-through read mode.
//
// Ports:
//   clock        - sole clock, rising edge
//   reset_n      - synchronous active-low reset (beats flush/wren/rden)
//   flush        - synchronous clear of FIFO state; q keeps its value
//   data         - write data
//   wren         - write request, accepted when not full
//   rden         - read request (standard) or pop/acknowledge (FWFT)
//   q            - read data (standard: 1 cycle after accept; FWFT: head word)
//   full         - count == DEPTH
//   empty        - count == 0
//   almost_full  - count >= AFULL_LEVEL
//   almost_empty - count <= AEMPTY_LEVEL
//   count        - number of words held (FWFT: includes the output register)
//   overflow     - sticky, a write was rejected because the FIFO was full
//   underflow    - sticky, a read was rejected because the FIFO was empty
// ---------------------------------------------------------------------------
module syncfifo_buf #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_LEVEL  = 12,
    parameter int AEMPTY_LEVEL = 2,
    parameter bit FWFT         = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wrptr;
    logic [ADDR_WIDTH-1:0] rdptr;

    // In FWFT mode the word sitting in q is counted but no longer lives in
    // the RAM; outvalid marks that q holds such a word.
    logic                  outvalid;

    logic                  active;
    logic                  accwr;
    logic                  accrd;
    logic                  ramwr;
    logic                  ramrd;
    logic                  bypass;
    logic                  needload;
    logic                  ramhas;
    logic                  outvalid_n;
    logic [ADDR_WIDTH:0]   ramcount;
    logic [ADDR_WIDTH:0]   count_n;

    // Accept decisions and the next-state count. In FWFT mode the output
    // register is refilled from the RAM whenever it is empty or being popped.
    // If the RAM has nothing to give, an incoming write goes straight into q
    // instead of the RAM. That bypass is what makes a write into an empty
    // FIFO visible one cycle later.
    always_comb begin
        active     = reset_n && !flush;
        accwr      = active && wren && !full;
        accrd      = active && rden && !empty;
        ramcount   = count - (ADDR_WIDTH+1)'(outvalid);
        ramhas     = (ramcount != '0);
        needload   = 1'b0;
        ramwr      = accwr;
        ramrd      = accrd;
        bypass     = 1'b0;
        outvalid_n = 1'b0;
        if (FWFT) begin
            needload   = !outvalid || accrd;
            ramrd      = active && needload && ramhas;
            bypass     = needload && !ramhas && accwr;
            ramwr      = accwr && !bypass;
            outvalid_n = (outvalid && !accrd) || ramrd || bypass;
        end
        count_n = count + (ADDR_WIDTH+1)'(accwr) - (ADDR_WIDTH+1)'(accrd);
    end

    // RAM write port. Contents are not cleared by reset or flush.
    always_ff @(posedge clock) begin
        if (ramwr) begin
            mem[wrptr] <= data;
        end
    end

    // Pointers, output register, count and registered flags. The flags are
    // computed from count_n so that they line up with count.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wrptr        <= '0;
            rdptr        <= '0;
            outvalid     <= 1'b0;
            q            <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (flush) begin
            wrptr        <= '0;
            rdptr        <= '0;
            outvalid     <= 1'b0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (ramwr) begin
                wrptr <= wrptr + ADDR_WIDTH'(1);
            end
            if (ramrd) begin
                rdptr <= rdptr + ADDR_WIDTH'(1);
                q     <= mem[rdptr];
            end else if (bypass) begin
                q <= data;
            end
            outvalid     <= outvalid_n;
            count        <= count_n;
            empty        <= (count_n == '0);
            full         <= (count_n == DEPTH_C);
            almost_empty <= (count_n <= AEMPTY_C);
            almost_full  <= (count_n >= AFULL_C);
            if (wren && full) begin
                overflow <= 1'b1;
            end
            if (rden && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_syncfifo_buf.sv
// ---------------------------------------------------------------------------
// tb_syncfifo_buf
//
// Self-checking bench for syncfifo_buf. A standard-mode instance and an FWFT
// instance see the same inputs. Both are compared against one queue-based
// reference model, because the held words and the count do not depend on
// the read mode. Only the expected q differs between the two instances.
// ---------------------------------------------------------------------------
module tb_syncfifo_buf;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        resetN;
    logic        flush;
    logic        wren;
    logic        rden;
    logic [31:0] data;

    // Index 0 is the standard-mode DUT and index 1 is the FWFT DUT.
    logic [31:0] qObs      [2];
    logic        fullObs   [2];
    logic        emptyObs  [2];
    logic        afullObs  [2];
    logic        aemptyObs [2];
    logic [4:0]  countObs  [2];
    logic        ovfObs    [2];
    logic        unfObs    [2];

    int          testsRun    = 0;
    int          testsFailed = 0;

    logic [31:0] modelQueue [$];
    logic [31:0] expQStd;
    logic [31:0] expQFwft;
    logic        expOvf;
    logic        expUnf;

    always #5 clock = ~clock;

    syncfifo_buf #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2), .FWFT(1'b0)
    ) dutStd (
        .clock(clock), .reset_n(resetN), .flush(flush), .data(data),
        .wren(wren), .rden(rden), .q(qObs[0]), .full(fullObs[0]),
        .empty(emptyObs[0]), .almost_full(afullObs[0]),
        .almost_empty(aemptyObs[0]), .count(countObs[0]),
        .overflow(ovfObs[0]), .underflow(unfObs[0])
    );

    syncfifo_buf #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .AFULL_LEVEL(12), .AEMPTY_LEVEL(2), .FWFT(1'b1)
    ) dutFwft (
        .clock(clock), .reset_n(resetN), .flush(flush), .data(data),
        .wren(wren), .rden(rden), .q(qObs[1]), .full(fullObs[1]),
        .empty(emptyObs[1]), .almost_full(afullObs[1]),
        .almost_empty(aemptyObs[1]), .count(countObs[1]),
        .overflow(ovfObs[1]), .underflow(unfObs[1])
    );

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs and step the reference model at the edge.
    // Then check both DUTs shortly after the edge and return on the falling
    // edge so that the next cycle can be driven.
    task automatic applyStimulus(input logic rst, input logic fl, input logic wr,
                                 input logic rd, input logic [31:0] d);
        int   sz;
        logic wasFull;
        logic wasEmpty;
        resetN = rst;
        flush  = fl;
        wren   = wr;
        rden   = rd;
        data   = d;
        @(posedge clock);
        if (!rst) begin
            modelQueue.delete();
            expQStd  = '0;
            expQFwft = '0;
            expOvf   = 1'b0;
            expUnf   = 1'b0;
        end else if (fl) begin
            modelQueue.delete();
            expOvf = 1'b0;
            expUnf = 1'b0;
        end else begin
            wasFull  = (modelQueue.size() == DEPTH);
            wasEmpty = (modelQueue.size() == 0);
            if (wr && wasFull)   expOvf = 1'b1;
            if (rd && wasEmpty)  expUnf = 1'b1;
            if (rd && !wasEmpty) expQStd = modelQueue.pop_front();
            if (wr && !wasFull)  modelQueue.push_back(d);
        end
        sz = modelQueue.size();
        if (sz > 0) expQFwft = modelQueue[0];
        #1;
        for (int m = 0; m < 2; m++) begin
            string md;
            md = (m == 0) ? "std" : "fwft";
            checkOutput({md, " count"},  32'(countObs[m]),  32'(sz));
            checkOutput({md, " empty"},  32'(emptyObs[m]),  32'(sz == 0));
            checkOutput({md, " full"},   32'(fullObs[m]),   32'(sz == DEPTH));
            checkOutput({md, " afull"},  32'(afullObs[m]),  32'(sz >= 12));
            checkOutput({md, " aempty"}, 32'(aemptyObs[m]), 32'(sz <= 2));
            checkOutput({md, " ovf"},    32'(ovfObs[m]),    32'(expOvf));
            checkOutput({md, " unf"},    32'(unfObs[m]),    32'(expUnf));
        end
        checkOutput("std q", qObs[0], expQStd);
        if (sz > 0) checkOutput("fwft q", qObs[1], expQFwft);
        @(negedge clock);
    endtask

    // Directed sequences first, then a long randomized run that also hits
    // flushes and resets at random points.
    initial begin
        int bias;
        resetN = 1'b0;
        flush  = 1'b0;
        wren   = 1'b0;
        rden   = 1'b0;
        data   = '0;
        expQStd  = '0;
        expQFwft = '0;
        expOvf   = 1'b0;
        expUnf   = 1'b0;

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("[TB] fill to full, then overflow");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'(i));
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("[TB] drain, underflow, flush");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

        $display("[TB] write into empty, back-to-back pops");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h2);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("[TB] steady write+read at count 5 across wrap");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, $urandom);

        $display("[TB] reset mid-stream with everything asserted");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, $urandom);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            bias = ((i / 100) % 2 == 1) ? 80 : 30;
            applyStimulus($urandom_range(0, 299) != 0,
                          $urandom_range(0, 79) == 0,
                          $urandom_range(0, 99) < bias,
                          $urandom_range(0, 99) < (100 - bias),
                          $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/syncfifo_buf.md
Name: syncfifo_buf

Overview:
Single-clock, parametrised FIFO built on an inferred simple-dual-port RAM with a registered read address. It is the successor to the CSI-2 receiver's dual-clock FIFO RAM, for paths that are already in one clock domain (byte-to-pixel staging, line buffering). It adds:
- full/empty and programmable almost-full/almost-empty flags
- a fill-level count
- sticky overflow and underflow error flags
- a synchronous flush
- a selectable standard or first-word-fall-through (FWFT) read mode

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words, minimum ADDR_WIDTH 2.
- AFULL_LEVEL, 12, almost_full asserts when count >= AFULL_LEVEL (legal range 1..DEPTH).
- AEMPTY_LEVEL, 2, almost_empty asserts when count <= AEMPTY_LEVEL (legal range 0..DEPTH-1).
- FWFT, 0, read mode: 0 = standard, 1 = first-word-fall-through.

Ports:
- clock  in  1  Sole clock; all logic is on its rising edge.
- reset_n  in  1  Synchronous, active-low reset.
- flush  in  1  Synchronous clear of FIFO contents state.
- data  in  DATA_WIDTH  Write data.
- wren  in  1  Write request.
- rden  in  1  Read request (FWFT=0) or pop/acknowledge (FWFT=1).
- q  out  DATA_WIDTH  Read data.
- full  out  1  count == DEPTH.
- empty  out  1  No readable word.
- almost_full  out  1  count >= AFULL_LEVEL.
- almost_empty  out  1  count <= AEMPTY_LEVEL.
- count  out  ADDR_WIDTH+1  Number of words held.
- overflow  out  1  Sticky: a write was rejected.
- underflow  out  1  Sticky: a read was rejected.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - wr/rd pointers = 0, count = 0, q = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0 (unless AFULL_LEVEL=0, which is illegal)
  - overflow = underflow = 0
  - RAM contents are not cleared.
  - Reset overrides flush, wren and rden in the same cycle.
- Flush (flush=1, reset_n=1):
  - Same state as reset except q holds its value.
  - Overrides wren and rden in that cycle; those requests are neither accepted nor flagged.
- Write:
  - Accepted when wren=1 and full=0.
  - Word is stored at wr_ptr; wr_ptr increments modulo DEPTH and wraps naturally.
  - wren=1 with full=1: write dropped, overflow set (sticky until reset/flush). This holds even if rden=1 in the same cycle.
- Read, FWFT=0:
  - Accepted when rden=1 and empty=0.
  - q updates with the head word exactly 1 cycle after the accepting edge; rd_ptr increments.
  - q holds its value when no read is accepted.
  - rden=1 with empty=1: no pop, q holds, underflow set. This holds even if wren=1 in the same cycle (no write-to-read bypass).
- Read, FWFT=1:
  - q always presents the head word whenever empty=0; rden=1 with empty=0 pops it.
  - The next word (if any) appears on q on the following cycle with no bubble.
  - A write into an empty FIFO makes empty=0 and q=that word 1 cycle after the write edge; this requires an internal bypass to the output register.
  - rden=1 with empty=1: underflow set, no state change.
  - count includes the word held in the output register.
- Count and flags:
  - count increments on an accepted write only, decrements on an accepted read only, and is unchanged when both are accepted.
  - All flags are registered and derived from the next-state count, so they are valid in the same cycle as count.
  - empty is (count==0) in both modes.
- Simultaneous accepted write and read when count==1 (FWFT=0): the write is stored, the read returns the old head, and count stays 1.
- Pointer wrap: after DEPTH writes and DEPTH reads, wr_ptr = rd_ptr = 0 with no corruption.
- RAM: one write port; read port uses a registered address (1-cycle latency), matching the existing FIFO RAM style. No read-during-write hazard can arise because the FIFO never reads an address in the same cycle it writes it.

Test Plan:
- Reset, then write 16 words 0x00000000..0x0000000F (FWFT=0, defaults) → full=1 after 16th edge; almost_full=1 when count reaches 12; count=16; overflow=0.
- Write 0xDEADBEEF while full → dropped; overflow=1 and stays 1; count stays 16. Then read 16 times → q = 0x0..0xF in order, each 1 cycle after rden; empty=1 at the end.
- Read while empty → underflow=1, q unchanged; assert flush → overflow=underflow=0, count=0, empty=1.
- FWFT=1: write 0xA5A5A5A5 into empty FIFO → next cycle empty=0, q=0xA5A5A5A5 with no rden. Write 0x1, 0x2, then pop 3× back-to-back → q sequence A5A5A5A5, 1, 2 on consecutive cycles, then empty=1.
- Continuous wren+rden for 40 cycles starting at count=5 → count stays 5; data is in order across pointer wrap (pointers pass 0 twice).
- Assert reset_n=0 mid-stream with wren=rden=flush=1 → next edge: count=0, empty=1, q=0, flags cleared. Subsequent writes and reads start at address 0.
